// File: rtl/bram_test_sequencer.sv
// bram_test_sequencer: run controller upstream of the BRAM test engine.
// Accepts one command, issues run_count test runs with stepped seeds,
// acknowledges each completion status and returns one aggregated result.
// Optional per-run watchdog: define BRAM_SEQ_TIMEOUT_EN.
module bram_test_sequencer #(
    parameter logic [31:0] SEED_STEP = 32'h9E3779B9,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic [79:0] cmd_tdata,
    output logic        seed_tvalid,
    input  logic        seed_tready,
    output logic [31:0] seed_tdata,
    output logic        addr_max_tvalid,
    input  logic        addr_max_tready,
    output logic [31:0] addr_max_tdata,
    input  logic [31:0] status_tdata,
    input  logic        status_tvalid,
    output logic        status_tready,
    input  logic        error,
    output logic        result_tvalid,
    input  logic        result_tready,
    output logic [63:0] result_tdata,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_ACK, S_REPORT} state_t;

    state_t      state_q, state_d;
    logic [15:0] run_count_q, run_count_d;
    logic [15:0] run_idx_q, run_idx_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] fail_q, fail_d;
    logic [15:0] first_fail_q, first_fail_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] addr_max_q, addr_max_d;
    logic        error_seen_q, error_seen_d;
    logic        timeout_q, timeout_d;
    logic [63:0] result_q, result_d;
    logic        cmd_tready_q, cmd_tready_d;
    logic        seed_tvalid_q, seed_tvalid_d;
    logic        addr_max_tvalid_q, addr_max_tvalid_d;
    logic        status_tready_q, status_tready_d;
    logic        result_tvalid_q, result_tvalid_d;
    logic        busy_q, busy_d;

`ifdef BRAM_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
    assign wd_inc = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
`else
    // Watchdog width has no meaning without the watchdog.
    localparam int unsigned UNUSED_TIMEOUT_W = TIMEOUT_W;
`endif

    // Only the done/passed bits of a status word carry information.
    logic unused_status_bits;
    assign unused_status_bits = ^status_tdata[31:2];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state, run bookkeeping and registered-output decode.
    always_comb begin
        state_d      = state_q;
        run_count_d  = run_count_q;
        run_idx_d    = run_idx_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        first_fail_d = first_fail_q;
        seed_d       = seed_q;
        addr_max_d   = addr_max_q;
        error_seen_d = error_seen_q;
        timeout_d    = timeout_q;
        result_d     = result_q;
`ifdef BRAM_SEQ_TIMEOUT_EN
        wd_d         = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_tvalid && cmd_tready_q) begin
                    run_count_d  = (cmd_tdata[79:64] == 16'd0) ? 16'd1 : cmd_tdata[79:64];
                    seed_d       = cmd_tdata[63:32];
                    addr_max_d   = cmd_tdata[31:0];
                    run_idx_d    = 16'd0;
                    pass_d       = 16'd0;
                    fail_d       = 16'd0;
                    first_fail_d = 16'hFFFF;
                    error_seen_d = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Seed and addr_max move as one transfer; a lone ready is not enough.
                if (seed_tready && addr_max_tready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                error_seen_d = error_seen_q | error;
                if (status_tvalid && status_tdata[1]) begin
                    if (status_tdata[0]) begin
                        pass_d = sat_inc16(pass_q);
                    end else begin
                        fail_d = sat_inc16(fail_q);
                        if (first_fail_q == 16'hFFFF) begin
                            first_fail_d = run_idx_q;
                        end
                    end
                    state_d = S_ACK;
                end
`ifdef BRAM_SEQ_TIMEOUT_EN
                else if (wd_inc == {TIMEOUT_W{1'b1}}) begin
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end
`endif
            end
            S_ACK: begin
                run_idx_d = run_idx_q + 16'd1;
                if (run_idx_d == run_count_q) begin
                    state_d = S_REPORT;
                end else begin
                    seed_d  = seed_q + SEED_STEP;
                    state_d = S_ISSUE;
                end
            end
            S_REPORT: begin
                if (result_tready && result_tvalid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef BRAM_SEQ_TIMEOUT_EN
        if (state_d == S_WAIT_DONE) begin
            wd_d = (state_q != S_WAIT_DONE) ? '0 : wd_inc;
        end
`endif

        // Result word is frozen on entry to REPORT so it cannot move while presented.
        if (state_d == S_REPORT && state_q != S_REPORT) begin
            result_d = {14'd0, error_seen_d, timeout_d, first_fail_d, fail_d, pass_d};
        end

        cmd_tready_d      = (state_d == S_IDLE);
        seed_tvalid_d     = (state_d == S_ISSUE);
        addr_max_tvalid_d = (state_d == S_ISSUE);
        status_tready_d   = (state_d == S_ACK);
        result_tvalid_d   = (state_d == S_REPORT);
        busy_d            = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any run with no result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q           <= S_IDLE;
            run_count_q       <= 16'd0;
            run_idx_q         <= 16'd0;
            pass_q            <= 16'd0;
            fail_q            <= 16'd0;
            first_fail_q      <= 16'd0;
            seed_q            <= 32'd0;
            addr_max_q        <= 32'd0;
            error_seen_q      <= 1'b0;
            timeout_q         <= 1'b0;
            result_q          <= 64'd0;
            cmd_tready_q      <= 1'b0;
            seed_tvalid_q     <= 1'b0;
            addr_max_tvalid_q <= 1'b0;
            status_tready_q   <= 1'b0;
            result_tvalid_q   <= 1'b0;
            busy_q            <= 1'b0;
`ifdef BRAM_SEQ_TIMEOUT_EN
            wd_q              <= '0;
`endif
        end else begin
            state_q           <= state_d;
            run_count_q       <= run_count_d;
            run_idx_q         <= run_idx_d;
            pass_q            <= pass_d;
            fail_q            <= fail_d;
            first_fail_q      <= first_fail_d;
            seed_q            <= seed_d;
            addr_max_q        <= addr_max_d;
            error_seen_q      <= error_seen_d;
            timeout_q         <= timeout_d;
            result_q          <= result_d;
            cmd_tready_q      <= cmd_tready_d;
            seed_tvalid_q     <= seed_tvalid_d;
            addr_max_tvalid_q <= addr_max_tvalid_d;
            status_tready_q   <= status_tready_d;
            result_tvalid_q   <= result_tvalid_d;
            busy_q            <= busy_d;
`ifdef BRAM_SEQ_TIMEOUT_EN
            wd_q              <= wd_d;
`endif
        end
    end

    assign cmd_tready      = cmd_tready_q;
    assign seed_tvalid     = seed_tvalid_q;
    assign seed_tdata      = seed_tvalid_q ? seed_q : 32'd0;
    assign addr_max_tvalid = addr_max_tvalid_q;
    assign addr_max_tdata  = addr_max_q;
    assign status_tready   = status_tready_q;
    assign result_tvalid   = result_tvalid_q;
    assign result_tdata    = result_q;
    assign busy            = busy_q;

endmodule
